// File: rtl/prog_loader_pkg.sv
// Shared constants for the program loader: state encoding, lane geometry and checksum width.
package prog_loader_pkg;

  localparam int BYTES_PER_WORD = 6;
  localparam int LANE_WIDTH     = 8;
  localparam int WORD_WIDTH     = BYTES_PER_WORD * LANE_WIDTH;
  localparam int CSUM_WIDTH     = 8;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LEN_LO = 3'd1;
  localparam state_t ST_LEN_HI = 3'd2;
  localparam state_t ST_DATA   = 3'd3;
  localparam state_t ST_WRITE  = 3'd4;
  localparam state_t ST_CSUM   = 3'd5;
  localparam state_t ST_DONE   = 3'd6;
  localparam state_t ST_ERROR  = 3'd7;

  function automatic logic [CSUM_WIDTH-1:0] csum_add(input logic [CSUM_WIDTH-1:0] sum,
                                                     input logic [LANE_WIDTH-1:0] lane);
    return sum + lane;
  endfunction

endpackage

// File: rtl/prog_loader_packer.sv
// Six-lane byte assembler: the byte on lane_data lands in lane lane_idx (bits 8i+7:8i) of word.
module prog_loader_packer
  import prog_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  _mr,
  input  logic                  load,
  input  logic [2:0]            lane_idx,
  input  logic [LANE_WIDTH-1:0] lane_data,
  output logic [WORD_WIDTH-1:0] word
);

  always_ff @(posedge clk or negedge _mr) begin
    if (!_mr) begin
      word <= '0;
    end else if (load) begin
      for (int i = 0; i < BYTES_PER_WORD; i++) begin
        if (lane_idx == 3'(i)) word[i*LANE_WIDTH +: LANE_WIDTH] <= lane_data;
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Streams a length-prefixed, checksummed image into 48-bit program memory while holding the CPU in reset.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  _mr,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [WORD_WIDTH-1:0] wr_data,
  output logic                  _cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [31:0] IDLE_LAST = TIMEOUT_CYCLES - 1;

  state_t                  state;
  logic [ADDR_WIDTH:0]     remaining;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [2:0]              byte_idx;
  logic [CSUM_WIDTH-1:0]   sum;
  logic [7:0]              len_lo;
  logic [31:0]             idle_cnt;
  logic                    loading;
  logic                    accept;
  logic                    timed_out;
  logic [15:0]             len_word;
  logic [ADDR_WIDTH:0]     first_count;

  assign loading = (state == ST_LEN_LO) || (state == ST_LEN_HI) ||
                   (state == ST_DATA)   || (state == ST_CSUM);
  assign accept  = in_valid && loading;
  assign timed_out = (TIMEOUT_CYCLES != 0) && loading && !accept && (idle_cnt == IDLE_LAST);

  // A zero length header selects the whole address space.
  assign len_word    = {in_data, len_lo};
  assign first_count = (len_word == 16'd0) ? {1'b1, {ADDR_WIDTH{1'b0}}}
                                           : (ADDR_WIDTH+1)'(len_word);

  always_ff @(posedge clk or negedge _mr) begin
    if (!_mr) begin
      state     <= ST_IDLE;
      remaining <= '0;
      addr      <= '0;
      byte_idx  <= '0;
      sum       <= '0;
      len_lo    <= '0;
      idle_cnt  <= '0;
    end else begin
      if (loading) idle_cnt <= accept ? 32'd0 : idle_cnt + 32'd1;
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state    <= ST_LEN_LO;
            sum      <= '0;
            addr     <= '0;
            byte_idx <= '0;
            idle_cnt <= '0;
          end
        end
        ST_LEN_LO: begin
          if (accept) begin
            len_lo <= in_data;
            sum    <= csum_add(sum, in_data);
            state  <= ST_LEN_HI;
          end
        end
        ST_LEN_HI: begin
          if (accept) begin
            remaining <= first_count;
            sum       <= csum_add(sum, in_data);
            state     <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (accept) begin
            sum <= csum_add(sum, in_data);
            if (byte_idx == 3'(BYTES_PER_WORD - 1)) begin
              byte_idx <= '0;
              state    <= ST_WRITE;
            end else begin
              byte_idx <= byte_idx + 3'd1;
            end
          end
        end
        ST_WRITE: begin
          // The address holds on the last word so it never wraps inside a load.
          remaining <= remaining - 1'b1;
          if (remaining == {{ADDR_WIDTH{1'b0}}, 1'b1}) begin
            state <= ST_CSUM;
          end else begin
            state <= ST_DATA;
            addr  <= addr + 1'b1;
          end
        end
        ST_CSUM: begin
          if (accept) state <= (in_data == sum) ? ST_DONE : ST_ERROR;
        end
        default: state <= ST_IDLE;
      endcase
      if (timed_out) state <= ST_ERROR;
    end
  end

  prog_loader_packer u_packer (
    .clk       (clk),
    ._mr       (_mr),
    .load      (accept && (state == ST_DATA)),
    .lane_idx  (byte_idx),
    .lane_data (in_data),
    .word      (wr_data)
  );

  assign in_ready   = loading;
  assign wr_en      = (state == ST_WRITE);
  assign wr_addr    = addr;
  assign busy       = loading || (state == ST_WRITE);
  assign done       = (state == ST_DONE);
  assign err        = (state == ST_ERROR);
  assign _cpu_reset = (state == ST_DONE);

endmodule
